// File: rtl/seg7_serial_drv.sv
// Serial driver for an eight-digit seven-segment display behind a shift-register chain.
// Each frame shifts 64 active-low segment bits MSB first, then pulses the storage latch.
module seg7_serial_drv #(
  parameter int unsigned DIV        = 2,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Hexs,
  input  logic [7:0]  points,
  input  logic [7:0]  LES,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_latch,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned DIGITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_n;
  logic [DIV_W-1:0]     div_q, div_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [FRAME_W-1:0]   frame_q, frame_n;
  logic [BLINK_BITS-1:0] blink_q;

  logic seg_clk_n, seg_sout_n, seg_latch_n, busy_n, done_n;
  logic div_last;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] seg_code(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit i lands in frame[8i+7:8i]; a blinking digit in its off phase is fully blank
  function automatic logic [FRAME_W-1:0] build_frame(input logic [31:0] hx,
                                                     input logic [7:0]  pt,
                                                     input logic [7:0]  le,
                                                     input logic        phase);
    logic [FRAME_W-1:0] f;
    logic [7:0]         digit_byte;
    f = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (le[i] && phase) digit_byte = 8'hFF;
      else                digit_byte = {~pt[i], seg_code(hx[4*i +: 4])};
      f[8*i +: 8] = digit_byte;
    end
    return f;
  endfunction

  assign div_last = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + BLINK_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      frame_q   <= frame_n;
      seg_clk   <= seg_clk_n;
      seg_sout  <= seg_sout_n;
      seg_latch <= seg_latch_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next state plus output decode of the next state, so outputs track the state register
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    frame_n = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_n = build_frame(Hexs, points, LES, blink_q[BLINK_BITS-1]);
          bit_n   = BIT_W'(FRAME_W - 1);
          div_n   = '0;
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (div_last) begin
          div_n   = '0;
          state_n = S_HIGH;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_n = '0;
          if (bit_q == '0) begin
            state_n = S_LATCH;
          end else begin
            bit_n   = bit_q - BIT_W'(1);
            state_n = S_LOW;
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_last) begin
          div_n   = '0;
          state_n = S_DONE;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    seg_clk_n   = (state_n == S_HIGH);
    seg_sout_n  = ((state_n == S_LOW) || (state_n == S_HIGH)) ? frame_n[bit_n] : 1'b0;
    seg_latch_n = (state_n == S_LATCH);
    busy_n      = (state_n == S_LOW) || (state_n == S_HIGH) || (state_n == S_LATCH);
    done_n      = (state_n == S_DONE);
  end

endmodule

// File: doc/seg7_serial_drv.md
SEG7_SERIAL_DRV -- requirements
Module: seg7_serial_drv

Interface
REQ-001 Parameter DIV, default 2, SHALL set the number of clk cycles for each seg_clk low phase, seg_clk high phase and seg_latch pulse (legal range 1..255).
REQ-002 Parameter BLINK_BITS, default 24, SHALL set the width of the free-running blink counter; its MSB is the blink phase.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame request; sampled only while busy=0.
REQ-006 Hexs  input  32  eight hex digits; digit i = Hexs[4i+3:4i], digit 7 is leftmost.
REQ-007 points  input  8  decimal point enable per digit; 1 = point lit.
REQ-008 LES  input  8  blink enable per digit; 1 = digit blinks.
REQ-009 seg_clk  output  1  serial shift clock to the external shift-register chain.
REQ-010 seg_sout  output  1  serial data, MSB first.
REQ-011 seg_latch  output  1  storage-register latch pulse, active-high.
REQ-012 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-013 done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 FSM states SHALL be IDLE, LOW, HIGH, LATCH, DONE, with one shared divider counter and a 6-bit bit index.
REQ-015 In IDLE with start=1, the block SHALL capture Hexs, points, LES and the current blink phase, build the 64-bit frame, set bit index 63 and enter LOW on the next cycle; busy rises in that same cycle.
REQ-016 Frame byte for digit i SHALL occupy frame[8i+7:8i] as {~dp, g, f, e, d, c, b, a}, segment bits active-low.
REQ-017 Active-low {g..a} codes, 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-018 dp bit SHALL be 0 when points[i]=1 and 1 otherwise.
REQ-019 When LES[i]=1 and the captured blink phase is 1, the digit byte SHALL be FF; points are also blanked.
REQ-020 LOW: seg_clk=0 and seg_sout=frame[bit index] for DIV cycles, then go to HIGH.
REQ-021 HIGH: seg_clk=1 for DIV cycles with seg_sout held; then, if bit index=0, go to LATCH, else decrement the bit index and return to LOW.
REQ-022 LATCH: seg_clk=0, seg_sout=0, seg_latch=1 for DIV cycles, then go to DONE.
REQ-023 DONE: done=1 and busy=0 for one cycle, then go to IDLE.
REQ-024 Frame latency from the start-accept edge to the done pulse SHALL be exactly 128*DIV + DIV + 1 cycles (259 at DIV=2).
REQ-025 start while busy=1 or during DONE SHALL be ignored; it is neither queued nor able to alter the captured frame.
REQ-026 start held high continuously SHALL start a new frame on every IDLE cycle, giving back-to-back frames separated by one IDLE cycle.
REQ-027 Input changes after capture SHALL NOT affect the frame in progress.
REQ-028 The blink counter SHALL free-run, wrap from all-ones to 0, and be independent of the FSM.

Reset
REQ-029 rst=1 SHALL force IDLE, blink counter=0, frame register=0, bit index=0 and divider=0.
REQ-030 While rst=1, and on the first cycle after it, the outputs SHALL be seg_clk=0, seg_sout=0, seg_latch=0, busy=0, done=0.
REQ-031 rst mid-frame SHALL abort immediately, with no latch pulse and no done pulse.
REQ-032 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-033 DIV=2; Hexs=01234567, points=00, LES=00, one start pulse -> 64 rising seg_clk edges; shifted stream = C0 F9 A4 B0 99 92 82 F8; then one seg_latch pulse of 2 cycles; done at cycle 259.
REQ-034 Hexs=89ABCDEF, points=81 -> stream 00 90 88 83 C6 A1 86 0E; dp cleared on digits 7 and 0 only.
REQ-035 BLINK_BITS=4; LES=01, Hexs=00000000; start while counter MSB=1, then again while MSB=0 -> digit 0 byte = FF, then C0; other digits C0 in both frames.
REQ-036 start pulsed at cycles 10 and 100 of a frame, with Hexs changed mid-frame -> frame unchanged, single done, no second frame.
REQ-037 rst asserted at bit index 30 -> next cycle all outputs 0, no seg_latch or done; a following start produces a complete correct frame.
REQ-038 start held high for 3 frames at DIV=1 -> done pulses 131 cycles apart (130-cycle frame plus one IDLE cycle), busy low exactly 2 cycles between frames.
